irq_prio_ctrl: RTL and testbench

//   Interrupt controller that gathers N raw interrupt sources and drives the src side of irq_if.
//   Per source: latches edge or level requests, applies an enable mask, picks the winner by priority.

---
 rtl/irq_prio_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_irq_prio_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// irq_prio_ctrl
//   Priority interrupt controller. It collects N raw interrupt lines. Each line
//   is latched as an edge or a level request. An enable mask is applied, and the
//   highest-priority eligible source is picked. Only one vector is presented at a
//   time, and it is held until the sink acknowledges it. The enabled pending
//   bitmap is also exported.
//
//   Optional feature macro: CARBON_IRQ_SYNC_EN
//     defined   : two-flop synchroniser on every irq_src bit (edge -> valid = 4 clk)
//     undefined : irq_src is used directly and must already be synchronous to clk
//
// Ports
//   clk               in   1          clock, all state on posedge
//   rst_n             in   1          asynchronous active-low reset
//   i_irq_src         in   N          raw interrupt request lines
//   i_cfg_enable      in   N          1 = source eligible for presentation
//   i_cfg_edge        in   N          1 = rising-edge triggered, 0 = level
//   i_cfg_prio        in   N*PRIO_W_E packed priorities, larger = higher
//   o_irq_valid       out  1          a vector is being presented
//   o_irq_vector      out  VEC_W      presented source index
//   o_irq_prio        out  PRIO_W_E   priority of the presented source
//   o_irq_pending     out  N          registered (pending & enable)
//   i_irq_ack         in   1          sink acknowledge strobe
//   i_irq_ack_vector  in   VEC_W      vector being acknowledged
// -----------------------------------------------------------------------------
module irq_prio_ctrl #(
    parameter  int N        = 32,
    parameter  int PRIO_W   = 0,
    localparam int VEC_W    = (N <= 1) ? 1 : $clog2(N),
    localparam int PRIO_W_E = (PRIO_W < 1) ? 1 : PRIO_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            i_irq_src,
    input  logic [N-1:0]            i_cfg_enable,
    input  logic [N-1:0]            i_cfg_edge,
    input  logic [N*PRIO_W_E-1:0]   i_cfg_prio,
    output logic                    o_irq_valid,
    output logic [VEC_W-1:0]        o_irq_vector,
    output logic [PRIO_W_E-1:0]     o_irq_prio,
    output logic [N-1:0]            o_irq_pending,
    input  logic                    i_irq_ack,
    input  logic [VEC_W-1:0]        i_irq_ack_vector
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [N-1:0]           w_s;
    logic [N-1:0]           r_src_q;
    logic [N-1:0]           r_pending;
    logic [N-1:0]           w_pend_nxt;
    logic [N-1:0]           w_rise;
    logic [N-1:0]           w_clr;
    logic [N-1:0]           w_eligible;

    logic                   r_irq_valid;
    logic [VEC_W-1:0]       r_irq_vector;
    logic [PRIO_W_E-1:0]    r_irq_prio;
    logic [N-1:0]           r_irq_pending;

    logic                   w_valid_nxt;
    logic [VEC_W-1:0]       w_vec_nxt;
    logic [PRIO_W_E-1:0]    w_prio_nxt;

    logic                   w_found;
    logic                   w_take;
    logic [PRIO_W_E-1:0]    w_cand_prio;
    logic [VEC_W-1:0]       w_win_vec;
    logic [PRIO_W_E-1:0]    w_win_prio;
    logic                   w_ack_ok;

`ifdef CARBON_IRQ_SYNC_EN
    logic [N-1:0]           r_sync1;
    logic [N-1:0]           r_sync2;

    // Two-flop synchroniser ahead of the edge/level logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_irq_src;
`endif

    // A sink acknowledge counts only while presenting and only for the held vector
    assign w_ack_ok   = (r_state == ST_PRESENT) && i_irq_ack &&
                        (i_irq_ack_vector == r_irq_vector);
    assign w_rise     = w_s & ~r_src_q;
    assign w_eligible = r_pending & i_cfg_enable;

    // Per-source clear strobe: only the acknowledged edge source is cleared
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            w_clr[i] = w_ack_ok && (r_irq_vector == VEC_W'(i)) && i_cfg_edge[i];
        end
    end

    // Pending next state. A fresh edge beats a same-cycle clear so it is not lost.
    // Level sources simply follow the sampled line.
    assign w_pend_nxt = (i_cfg_edge  & (w_rise | (r_pending & ~w_clr))) |
                        (~i_cfg_edge & w_s);

    // Arbitration: a strictly greater priority is needed to displace an earlier
    // winner, so ties resolve to the lowest index
    always_comb begin
        w_found     = 1'b0;
        w_take      = 1'b0;
        w_cand_prio = '0;
        w_win_vec   = '0;
        w_win_prio  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand_prio = (PRIO_W == 0) ? '0 : i_cfg_prio[i*PRIO_W_E +: PRIO_W_E];
            w_take      = w_eligible[i] && (!w_found || (w_cand_prio > w_win_prio));
            w_win_vec   = w_take ? VEC_W'(i) : w_win_vec;
            w_win_prio  = w_take ? w_cand_prio : w_win_prio;
            w_found     = w_found | w_eligible[i];
        end
    end

    // Presentation FSM next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_irq_valid;
        w_vec_nxt   = r_irq_vector;
        w_prio_nxt  = r_irq_prio;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_PRESENT;
                    w_valid_nxt = 1'b1;
                    w_vec_nxt   = w_win_vec;
                    w_prio_nxt  = w_win_prio;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_PRESENT: begin
                // Vector and priority stay sticky until a matching ack arrives
                if (w_ack_ok) begin
                    w_state_nxt = ST_GAP;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_PRESENT;
                    w_valid_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                // One idle cycle so level lines and enables re-evaluate
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_src_q       <= '0;
            r_pending     <= '0;
            r_irq_valid   <= 1'b0;
            r_irq_vector  <= '0;
            r_irq_prio    <= '0;
            r_irq_pending <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_src_q       <= w_s;
            r_pending     <= w_pend_nxt;
            r_irq_valid   <= w_valid_nxt;
            r_irq_vector  <= w_vec_nxt;
            r_irq_prio    <= w_prio_nxt;
            r_irq_pending <= w_eligible;
        end
    end

    assign o_irq_valid   = r_irq_valid;
    assign o_irq_vector  = r_irq_vector;
    assign o_irq_prio    = r_irq_prio;
    assign o_irq_pending = r_irq_pending;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_prio_ctrl
//   Directed bench for irq_prio_ctrl with N=16, PRIO_W=2.
//   Expected values are hand-computed. Each step drives its inputs 1 ns after a
//   rising edge and samples the outputs at that same point.
// -----------------------------------------------------------------------------
module tb_irq_prio_ctrl;

    localparam int N     = 16;
    localparam int PW    = 2;
    localparam int VEC_W = 4;
`ifdef CARBON_IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       irq_src;
    logic [N-1:0]       cfg_enable;
    logic [N-1:0]       cfg_edge;
    logic [N*PW-1:0]    cfg_prio;
    logic               irq_valid;
    logic [VEC_W-1:0]   irq_vector;
    logic [PW-1:0]      irq_prio;
    logic [N-1:0]       irq_pending;
    logic               irq_ack;
    logic [VEC_W-1:0]   irq_ack_vector;

    int n_cmp;
    int n_err;

    irq_prio_ctrl #(.N(N), .PRIO_W(PW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_irq_src        (irq_src),
        .i_cfg_enable     (cfg_enable),
        .i_cfg_edge       (cfg_edge),
        .i_cfg_prio       (cfg_prio),
        .o_irq_valid      (irq_valid),
        .o_irq_vector     (irq_vector),
        .o_irq_prio       (irq_prio),
        .o_irq_pending    (irq_pending),
        .i_irq_ack        (irq_ack),
        .i_irq_ack_vector (irq_ack_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && irq_valid !== 1'b1; k++) tick();
        chk(tag, {31'd0, irq_valid}, 32'd1);
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        irq_src = irq_src | bits;
        tick();
        irq_src = irq_src & ~bits;
    endtask

    task automatic ack(input logic [VEC_W-1:0] v);
        irq_ack        = 1'b1;
        irq_ack_vector = v;
        tick();
        irq_ack        = 1'b0;
        irq_ack_vector = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b1;
        irq_src        = 16'h0000;
        irq_ack        = 1'b0;
        irq_ack_vector = 4'd0;
        cfg_edge       = 16'hFF7F;          // src 7 is level
        cfg_enable     = 16'hFFFB;          // src 2 disabled
        cfg_prio       = 32'h0000_0000;
        cfg_prio[5*PW +: PW] = 2'd1;
        cfg_prio[9*PW +: PW] = 2'd3;
        cfg_prio[4*PW +: PW] = 2'd2;
        cfg_prio[6*PW +: PW] = 2'd2;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",   {31'd0, irq_valid}, 32'd0);
        chk("rst_vector",  {28'd0, irq_vector}, 32'd0);
        chk("rst_prio",    {30'd0, irq_prio}, 32'd0);
        chk("rst_pending", {16'd0, irq_pending}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_valid", {31'd0, irq_valid}, 32'd0);

        // ---- edge src 3: valid two cycles after the pulse ----
        pulse(16'h0008);
        repeat (1 + L) tick();
        chk("e3_valid",   {31'd0, irq_valid}, 32'd1);
        chk("e3_vector",  {28'd0, irq_vector}, 32'd3);
        chk("e3_prio",    {30'd0, irq_prio}, 32'd0);
        chk("e3_pending", {16'd0, irq_pending}, 32'h0008);
        tick();
        chk("e3_hold",    {28'd0, irq_vector}, 32'd3);
        ack(4'd1);                          // mismatched ack is ignored
        chk("badack_valid",  {31'd0, irq_valid}, 32'd1);
        chk("badack_vector", {28'd0, irq_vector}, 32'd3);
        ack(4'd3);
        chk("ack3_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("gap_valid",  {31'd0, irq_valid}, 32'd0);
        tick();
        chk("post3_valid",   {31'd0, irq_valid}, 32'd0);
        chk("post3_pending", {16'd0, irq_pending}, 32'd0);

        // ---- priority: src 9 (prio 3) beats src 5 (prio 1) ----
        pulse(16'h0220);
        repeat (1 + L) tick();
        chk("p9_valid",  {31'd0, irq_valid}, 32'd1);
        chk("p9_vector", {28'd0, irq_vector}, 32'd9);
        chk("p9_prio",   {30'd0, irq_prio}, 32'd3);
        ack(4'd9);
        chk("p9_ack_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("p9_gap_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("p5_valid",  {31'd0, irq_valid}, 32'd1);
        chk("p5_vector", {28'd0, irq_vector}, 32'd5);
        chk("p5_prio",   {30'd0, irq_prio}, 32'd1);
        ack(4'd5);
        tick();
        tick();

        // ---- tie at prio 2: src 4 before src 6 ----
        pulse(16'h0050);
        repeat (1 + L) tick();
        chk("t4_vector", {28'd0, irq_vector}, 32'd4);
        chk("t4_prio",   {30'd0, irq_prio}, 32'd2);
        ack(4'd4);
        tick();
        tick();
        chk("t6_valid",  {31'd0, irq_valid}, 32'd1);
        chk("t6_vector", {28'd0, irq_vector}, 32'd6);
        ack(4'd6);
        tick();
        tick();

        // ---- level src 7 held through ack, then dropped ----
        irq_src[7] = 1'b1;
        tick();
        repeat (1 + L) tick();
        chk("l7_valid",  {31'd0, irq_valid}, 32'd1);
        chk("l7_vector", {28'd0, irq_vector}, 32'd7);
        ack(4'd7);
        chk("l7_ack_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        tick();
        chk("l7_re_valid",   {31'd0, irq_valid}, 32'd1);
        chk("l7_re_vector",  {28'd0, irq_vector}, 32'd7);
        chk("l7_re_pending", {16'd0, irq_pending}, 32'h0080);
        irq_src[7] = 1'b0;
        repeat (L) tick();
        ack(4'd7);
        tick();
        tick();
        tick();
        chk("l7_drop_valid",   {31'd0, irq_valid}, 32'd0);
        chk("l7_drop_pending", {16'd0, irq_pending}, 32'd0);

        // ---- edge on disabled src 2 is latched, delivered once enabled ----
        pulse(16'h0004);
        repeat (1 + L) tick();
        tick();
        chk("d2_valid",   {31'd0, irq_valid}, 32'd0);
        chk("d2_pending", {16'd0, irq_pending}, 32'd0);
        cfg_enable[2] = 1'b1;
        tick();
        chk("en2_valid",   {31'd0, irq_valid}, 32'd1);
        chk("en2_vector",  {28'd0, irq_vector}, 32'd2);
        chk("en2_pending", {16'd0, irq_pending}, 32'h0004);
        ack(4'd2);
        tick();
        tick();

        // ---- new edge on 3 in its own ack cycle is re-presented ----
        pulse(16'h0008);
        repeat (1 + L) tick();
        chk("r3_vector", {28'd0, irq_vector}, 32'd3);
        irq_src[3] = 1'b1;
        ack(4'd3);
        irq_src[3] = 1'b0;
        chk("r3_ack_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        chk("r3_gap_valid", {31'd0, irq_valid}, 32'd0);
        wait_valid("r3_re_valid", 8);
        chk("r3_re_vector", {28'd0, irq_vector}, 32'd3);
        ack(4'd3);
        tick();
        tick();

        // ---- reset mid-PRESENT clears everything asynchronously ----
        pulse(16'h0200);
        repeat (1 + L) tick();
        chk("m9_valid", {31'd0, irq_valid}, 32'd1);
        irq_src[9] = 1'b1;                  // line stays high across reset
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",   {31'd0, irq_valid}, 32'd0);
        chk("mrst_vector",  {28'd0, irq_vector}, 32'd0);
        chk("mrst_prio",    {30'd0, irq_prio}, 32'd0);
        chk("mrst_pending", {16'd0, irq_pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        // a line already high after reset counts as an edge
        wait_valid("post_rst_valid", 8);
        chk("post_rst_vector", {28'd0, irq_vector}, 32'd9);
        irq_src[9] = 1'b0;
        ack(4'd9);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
